// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Buffers ALU/MEM results, grants one per cycle, forwards the commit.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 4,
  parameter int MEM_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              writeReg,
  output logic [ADDR_W-1:0] dstReg,
  output logic [DATA_W-1:0] dstData,
  input  logic [ADDR_W-1:0] srcReg_1,
  input  logic [ADDR_W-1:0] srcReg_2,
  input  logic [DATA_W-1:0] rfData_1,
  input  logic [DATA_W-1:0] rfData_2,
  output logic [DATA_W-1:0] fwdData_1,
  output logic [DATA_W-1:0] fwdData_2
);

  logic              aluFull;
  logic [ADDR_W-1:0] aluReg;
  logic [DATA_W-1:0] aluData;
  logic              memFull;
  logic [ADDR_W-1:0] memReg;
  logic [DATA_W-1:0] memData;
  logic              lastGrant;
  logic              grantAlu;
  logic              grantMem;
  logic              memWins;

  // lastGrant: 0 = ALU, 1 = MEM
  assign memWins = (MEM_PRIORITY != 0) || !lastGrant;

  always_comb begin
    grantAlu = 1'b0;
    grantMem = 1'b0;
    unique case (1'b1)
      (aluFull && !memFull): grantAlu = 1'b1;
      (memFull && !aluFull): grantMem = 1'b1;
      (aluFull && memFull): begin
        grantMem = memWins;
        grantAlu = !memWins;
      end
      default: ;
    endcase
  end

  assign alu_ready = !rst && (!aluFull || grantAlu);
  assign mem_ready = !rst && (!memFull || grantMem);

  always_ff @(posedge clk) begin
    if (rst) begin
      aluFull   <= 1'b0;
      aluReg    <= '0;
      aluData   <= '0;
      memFull   <= 1'b0;
      memReg    <= '0;
      memData   <= '0;
      lastGrant <= 1'b1;
      writeReg  <= 1'b0;
      dstReg    <= '0;
      dstData   <= '0;
    end else begin
      if (alu_valid && alu_ready) begin
        aluFull <= 1'b1;
        aluReg  <= alu_reg;
        aluData <= alu_data;
      end else if (grantAlu) begin
        aluFull <= 1'b0;
      end

      if (mem_valid && mem_ready) begin
        memFull <= 1'b1;
        memReg  <= mem_reg;
        memData <= mem_data;
      end else if (grantMem) begin
        memFull <= 1'b0;
      end

      if (grantAlu || grantMem) begin
        writeReg  <= 1'b1;
        dstReg    <= grantAlu ? aluReg : memReg;
        dstData   <= grantAlu ? aluData : memData;
        lastGrant <= grantMem;
      end else begin
        writeReg <= 1'b0;
      end
    end
  end

  // Only the committing write is visible; buffered entries are not.
  assign fwdData_1 = (writeReg && dstReg == srcReg_1) ? dstData : rfData_1;
  assign fwdData_2 = (writeReg && dstReg == srcReg_2) ? dstData : rfData_2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: round-robin instance plus a MEM-priority instance.
// Inputs change on falling edges; outputs are checked there too.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        aV, aRdy, mV, mRdy, wr;
  logic [3:0]  aR, mR, dR, s1, s2;
  logic [15:0] aD, mD, dD, rf1, rf2, f1, f2;

  logic        aV1, aRdy1, mV1, mRdy1, wr1;
  logic [3:0]  aR1, mR1, dR1;
  logic [15:0] aD1, mD1, dD1, f11, f12;

  logic [15:0] rfm [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.MEM_PRIORITY(0)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(aV), .alu_ready(aRdy),
    .alu_reg(aR), .alu_data(aD),
    .mem_valid(mV), .mem_ready(mRdy),
    .mem_reg(mR), .mem_data(mD),
    .writeReg(wr), .dstReg(dR), .dstData(dD),
    .srcReg_1(s1), .srcReg_2(s2),
    .rfData_1(rf1), .rfData_2(rf2),
    .fwdData_1(f1), .fwdData_2(f2)
  );

  regfile_wb_arbiter #(.MEM_PRIORITY(1)) dutP (
    .clk(clk), .rst(rst),
    .alu_valid(aV1), .alu_ready(aRdy1),
    .alu_reg(aR1), .alu_data(aD1),
    .mem_valid(mV1), .mem_ready(mRdy1),
    .mem_reg(mR1), .mem_data(mD1),
    .writeReg(wr1), .dstReg(dR1), .dstData(dD1),
    .srcReg_1(s1), .srcReg_2(s2),
    .rfData_1(rf1), .rfData_2(rf2),
    .fwdData_1(f11), .fwdData_2(f12)
  );

  always @(posedge clk)
    if (wr) rfm[dR] <= dD;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic commit(input string tag, input logic [31:0] r,
                        input logic [31:0] d);
    chk({tag, ".wr"}, 32'(wr), 1);
    chk({tag, ".reg"}, 32'(dR), r);
    chk({tag, ".data"}, 32'(dD), d);
  endtask

  initial begin
    rst = 1'b1;
    aV = 0; aR = 0; aD = 0; mV = 0; mR = 0; mD = 0;
    aV1 = 0; aR1 = 0; aD1 = 0; mV1 = 0; mR1 = 0; mD1 = 0;
    s1 = 0; s2 = 0; rf1 = 0; rf2 = 0;
    #1;
    chk("rst.aRdy0", 32'(aRdy), 0);
    chk("rst.mRdy0", 32'(mRdy), 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst.wr", 32'(wr), 0);
    chk("rst.dR", 32'(dR), 0);
    chk("rst.dD", 32'(dD), 0);
    chk("rst.aRdy", 32'(aRdy), 0);
    chk("rst.mRdy", 32'(mRdy), 0);
    rst = 1'b0;
    #1;
    chk("idle.aRdy", 32'(aRdy), 1);
    chk("idle.mRdy", 32'(mRdy), 1);

    // contention right after reset: ALU first
    aV = 1; aR = 5; aD = 16'h1111;
    mV = 1; mR = 5; mD = 16'h2222;
    @(negedge clk);
    aV = 0; mV = 0;
    chk("rr1.lat", 32'(wr), 0);
    @(negedge clk);
    commit("rr1.first", 5, 'h1111);
    @(negedge clk);
    commit("rr1.second", 5, 'h2222);
    @(negedge clk);
    chk("rr1.idle", 32'(wr), 0);
    chk("rr1.R5", 32'(rfm[5]), 'h2222);

    // single ALU write, two-cycle latency
    aV = 1; aR = 3; aD = 16'hBEEF;
    @(negedge clk);
    aV = 0;
    chk("alu.lat", 32'(wr), 0);
    @(negedge clk);
    commit("alu", 3, 'hBEEF);
    @(negedge clk);
    chk("alu.once", 32'(wr), 0);
    chk("alu.R3", 32'(rfm[3]), 'hBEEF);

    // last grant was ALU, so MEM wins this contention
    aV = 1; aR = 6; aD = 16'hAAAA;
    mV = 1; mR = 6; mD = 16'hBBBB;
    @(negedge clk);
    aV = 0; mV = 0;
    chk("rr2.lat", 32'(wr), 0);
    @(negedge clk);
    commit("rr2.first", 6, 'hBBBB);
    @(negedge clk);
    commit("rr2.second", 6, 'hAAAA);
    @(negedge clk);
    chk("rr2.R6", 32'(rfm[6]), 'hAAAA);

    // forwarding
    aV = 1; aR = 7; aD = 16'hA5A5;
    @(negedge clk);
    aV = 0;
    @(negedge clk);
    commit("fwd", 7, 'hA5A5);
    s1 = 7; s2 = 2; rf1 = 16'h0000; rf2 = 16'h1234;
    #1;
    chk("fwd.p1", 32'(f1), 'hA5A5);
    chk("fwd.p2", 32'(f2), 'h1234);
    s2 = 7;
    #1;
    chk("fwd.same", 32'(f2), 'hA5A5);
    @(negedge clk);
    s2 = 2;
    #1;
    chk("fwd.off1", 32'(f1), 'h0000);
    chk("fwd.off2", 32'(f2), 'h1234);

    // reset with both buffers full and a commit in flight
    @(negedge clk);
    aV = 1; aR = 8; aD = 16'h0101;
    mV = 1; mR = 9; mD = 16'h0202;
    @(negedge clk);
    aV = 0;
    chk("mid.mRdy", 32'(mRdy), 1);
    chk("mid.aRdy", 32'(aRdy), 0);
    mR = 11; mD = 16'h0404;
    @(negedge clk);
    mV = 0;
    commit("mid.mem", 9, 'h0202);
    chk("mid.aGrant", 32'(aRdy), 1);
    chk("mid.mHold", 32'(mRdy), 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid.rstWr", 32'(wr), 0);
    chk("mid.rstDr", 32'(dR), 0);
    chk("mid.rstDd", 32'(dD), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid.noCommit", 32'(wr), 0);
    end
    aV = 1; aR = 12; aD = 16'h1212;
    mV = 1; mR = 12; mD = 16'h3434;
    @(negedge clk);
    aV = 0; mV = 0;
    @(negedge clk);
    commit("mid.aluFirst", 12, 'h1212);
    @(negedge clk);
    commit("mid.memNext", 12, 'h3434);

    // MEM priority with both streams continuous
    aV1 = 1; aR1 = 4'hA; aD1 = 16'hAAA0;
    mV1 = 1;
    for (int k = 0; k <= 6; k++) begin
      if (k >= 2) begin
        chk("prio.wr", 32'(wr1), 1);
        chk("prio.data", 32'(dD1), 32'h2000 + 32'(k - 2));
      end
      if (k >= 1) begin
        chk("prio.mRdy", 32'(mRdy1), 1);
        chk("prio.aRdy", 32'(aRdy1), 0);
      end
      mR1 = 4'(k);
      mD1 = 16'h2000 + 16'(k);
      @(negedge clk);
    end
    mV1 = 0;
    chk("prio.tail", 32'(dD1), 'h2005);
    chk("prio.aHold", 32'(aRdy1), 0);
    @(negedge clk);
    chk("prio.last", 32'(dD1), 'h2006);
    chk("prio.aFree", 32'(aRdy1), 1);
    aV1 = 0;
    @(negedge clk);
    chk("prio.aluReg", 32'(dR1), 'hA);
    chk("prio.aluData", 32'(dD1), 'hAAA0);
    @(negedge clk);
    chk("prio.idle", 32'(wr1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
